// File: rtl/digit_serial_adder_if.sv
// Handshake and data bundle for digit_serial_adder: operand channel in, result channel out.
// The sub line exists only when DIGIT_SERIAL_ADDER_SUB_EN is defined.
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum_o;
    logic             busy;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum_o, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum_o, busy
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle unsigned adder: adds DIGIT bits per clock, LSB first, through a carry register.
// Optional A-B mode enabled by defining DIGIT_SERIAL_ADDER_SUB_EN.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_serial_adder_if.slave   bus
);
    localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] acc_shift;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;

    // Subtraction is a + ~b + 1; the inversion and the initial carry are fixed at accept time.
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign b_load     = bus.b ^ {WIDTH{bus.sub}};
    assign carry_init = bus.sub;
`else
    assign b_load     = bus.b;
    assign carry_init = 1'b0;
`endif

    assign digit_sum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the MSB end so the final digit lands in the top slot.
    assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = b_load;
                    acc_d   = '0;
                    carry_d = carry_init;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = digit_sum[DIGIT];
                acc_d   = acc_shift;
                a_sh_d  = a_sh_q >> DIGIT;
                b_sh_d  = b_sh_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NDIG - 1)) begin
                    sum_d       = {digit_sum[DIGIT], acc_shift};
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum_o     = sum_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_digit_serial_adder;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic sub);
        longint unsigned ua, ub, modv, r;
        ua   = 64'(a);
        ub   = 64'(b);
        modv = 64'd1 << WIDTH;
        if (sub) begin
            r = (ua + modv - ub) % modv;
            if (ua >= ub) r = r + modv;
        end else begin
            r = ua + ub;
        end
        return (WIDTH+1)'(r);
    endfunction

    // Caller is at a negedge. Issues one operation and follows it through to the result handshake.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input int stall, input bit corrupt,
                          input logic [WIDTH:0] exp);
        int t;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_wait"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        bus.sub       = sub;
`endif
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        check({tag, "_accept_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_accept_ready"}, 64'(bus.in_ready), 64'd0);
        for (int k = 1; k <= NDIG; k++) begin
            bus.in_valid = corrupt;
            if (corrupt) begin
                bus.a = WIDTH'($urandom);
                bus.b = WIDTH'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
                bus.sub = 1'($urandom);
`endif
            end
            @(posedge clk);
            #1;
            check($sformatf("%s_valid_e%0d", tag, k), 64'(bus.out_valid), 64'(k == NDIG));
            check($sformatf("%s_busy_e%0d", tag, k), 64'(bus.busy), 64'd1);
        end
        check({tag, "_sum"}, 64'(bus.sum_o), 64'(exp));
        check({tag, "_done_ready"}, 64'(bus.in_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hold_valid%0d", tag, s), 64'(bus.out_valid), 64'd1);
            check($sformatf("%s_hold_sum%0d", tag, s), 64'(bus.sum_o), 64'(exp));
            check($sformatf("%s_hold_ready%0d", tag, s), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_drop_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_keep_sum"}, 64'(bus.sum_o), 64'(exp));
        if (corrupt) begin
            @(posedge clk);
            #1;
            check({tag, "_single_result"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_stay_idle"}, 64'(bus.busy), 64'd0);
        end
        @(negedge clk);
        $display("op %s a=%0h b=%0h sub=%0b stall=%0d sum=%0h exp=%0h",
                 tag, a, b, sub, stall, bus.sum_o, exp);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        bus.sub       = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_sum", 64'(bus.sum_o), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("d15p1",   8'd15,  8'd1,   1'b0, 0, 1'b0, 9'h010);
        run_op("d255p255",8'd255, 8'd255, 1'b0, 0, 1'b0, 9'h1FE);
        run_op("d0p0",    8'd0,   8'd0,   1'b0, 0, 1'b0, 9'h000);
        run_op("bp100p27",8'd100, 8'd27,  1'b0, 6, 1'b0, 9'h07F);
        run_op("corrupt", 8'hA5,  8'h5A,  1'b0, 2, 1'b1, 9'h0FF);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        run_op("s7m5",    8'd7,   8'd5,   1'b1, 0, 1'b0, 9'h102);
        run_op("s5m7",    8'd5,   8'd7,   1'b1, 1, 1'b0, 9'h0FE);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`endif
            run_op($sformatf("rnd%0d", i), ra, rb, rs, int'($urandom_range(0, 3)),
                   1'($urandom), ref_result(ra, rb, rs));
        end

        // Abort: leave a nonzero result behind, then reset during the second RUN cycle.
        run_op("d200p100", 8'd200, 8'd100, 1'b0, 0, 1'b0, 9'h12C);
        bus.in_valid = 1'b1;
        bus.a        = 8'd33;
        bus.b        = 8'd44;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_sum", 64'(bus.sum_o), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NDIG + 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_noresult%0d", c), 64'(bus.out_valid | bus.busy), 64'd0);
        end
        @(negedge clk);
        run_op("recover", 8'd128, 8'd128, 1'b0, 1, 1'b0, ref_result(8'd128, 8'd128, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
